// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the MIPS ALU control and multiply/divide unit.
// ALU codes, function fields, alu_op values and the MDU state type.
package alu_ctrl_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;
    localparam logic [3:0] ALU_SRL = 4'b1101;
    localparam logic [3:0] ALU_SLL = 4'b1110;
    localparam logic [3:0] ALU_NOP = 4'b1111;

    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_SLT   = 6'b101010;
    localparam logic [5:0] F_SLL   = 6'b000000;
    localparam logic [5:0] F_SRL   = 6'b000010;
    localparam logic [5:0] F_NOR   = 6'b100111;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;

    typedef enum logic [1:0] {
        OP_ADD   = 2'b00,
        OP_SUB   = 2'b01,
        OP_RTYPE = 2'b10,
        OP_OR    = 2'b11
    } alu_op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX
    } mdu_state_e;

endpackage

// File: rtl/mdu_iter.sv
// Iterative radix-2 multiply (shift-add) / divide (restoring) datapath.
// Works on magnitudes; signs are reapplied combinationally in FIX.
module mdu_iter
    import alu_ctrl_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sgn,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    mdu_state_e state, next;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] acc, q, m;
    logic sa, sb, div_op, b_zero;

    logic [WIDTH-1:0] a_abs, b_abs;
    logic [WIDTH:0] sum, shl;
    logic [WIDTH-1:0] diff;
    logic ge;
    logic [2*WIDTH-1:0] prod, prod_s;
    logic [WIDTH-1:0] quo, rem;

    assign a_abs = (sgn & a[WIDTH-1]) ? -a : a;
    assign b_abs = (sgn & b[WIDTH-1]) ? -b : b;

    // acc/q form the product (mult) or remainder/quotient (div) pair
    assign sum  = {1'b0, acc} + (q[0] ? {1'b0, m} : '0);
    assign shl  = {acc, q[WIDTH-1]};
    assign ge   = shl >= {1'b0, m};
    assign diff = shl[WIDTH-1:0] - m;

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= next;
    end

    always_comb begin
        next = state;
        case (state)
            S_IDLE: if (start) next = S_RUN;
            S_RUN:  if (cnt == CNT_W'(1)) next = S_FIX;
            S_FIX:  next = S_IDLE;
            default: next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            acc    <= '0;
            q      <= '0;
            m      <= '0;
            sa     <= 1'b0;
            sb     <= 1'b0;
            div_op <= 1'b0;
            b_zero <= 1'b0;
        end else if (state == S_IDLE) begin
            if (start) begin
                cnt    <= CNT_W'(WIDTH);
                acc    <= '0;
                q      <= is_div ? a_abs : b_abs;
                m      <= is_div ? b_abs : a_abs;
                sa     <= sgn & a[WIDTH-1];
                sb     <= sgn & b[WIDTH-1];
                div_op <= is_div;
                b_zero <= (b == '0);
            end
        end else if (state == S_RUN) begin
            cnt <= cnt - CNT_W'(1);
            if (div_op) begin
                acc <= ge ? diff : shl[WIDTH-1:0];
                q   <= {q[WIDTH-2:0], ge};
            end else begin
                acc <= sum[WIDTH:1];
                q   <= {sum[0], q[WIDTH-1:1]};
            end
        end
    end

    assign prod   = {acc, q};
    assign prod_s = (sa ^ sb) ? -prod : prod;
    assign quo    = (sa ^ sb) ? -q : q;
    assign rem    = sa ? -acc : acc;

    // divide by zero reports an all-ones quotient regardless of sign
    assign hi   = div_op ? rem : prod_s[2*WIDTH-1:WIDTH];
    assign lo   = div_op ? (b_zero ? '1 : quo) : prod_s[WIDTH-1:0];
    assign done = (state == S_FIX);
    assign busy = (state != S_IDLE);

endmodule

// File: rtl/alu_control_mdu.sv
// ALU control decode plus multiply/divide unit with HI/LO and issue interlock.
// Decode is purely combinational; HI/LO update on mthi/mtlo or MDU completion.
module alu_control_mdu
    import alu_ctrl_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       alu_op,
    input  logic [5:0]       func,
    input  logic             valid,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic [3:0]       alu_ctrl,
    output logic             illegal,
    output logic             stall,
    output logic             busy,
    output logic [WIDTH-1:0] mf_data,
    output logic             mf_sel
);

    logic md_func, md_op, accept, start;
    logic done;
    logic [WIDTH-1:0] hi_r, lo_r, res_hi, res_lo;

    always_comb begin
        alu_ctrl = ALU_NOP;
        illegal  = 1'b0;
        md_func  = 1'b0;
        unique case (alu_op)
            OP_ADD: alu_ctrl = ALU_ADD;
            OP_SUB: alu_ctrl = ALU_SUB;
            OP_OR:  alu_ctrl = ALU_OR;
            OP_RTYPE: begin
                case (func)
                    F_ADD: alu_ctrl = ALU_ADD;
                    F_SUB: alu_ctrl = ALU_SUB;
                    F_AND: alu_ctrl = ALU_AND;
                    F_OR:  alu_ctrl = ALU_OR;
                    F_SLT: alu_ctrl = ALU_SLT;
                    F_SLL: alu_ctrl = ALU_SLL;
                    F_SRL: alu_ctrl = ALU_SRL;
                    F_NOR: alu_ctrl = ALU_NOR;
                    F_MULT, F_MULTU, F_DIV, F_DIVU,
                    F_MFHI, F_MFLO, F_MTHI, F_MTLO: md_func = 1'b1;
                    default: illegal = 1'b1;
                endcase
            end
        endcase
    end

    assign md_op  = valid & md_func;
    assign stall  = busy & md_op;
    assign accept = md_op & ~stall;

    // func 0110xx: bit0 selects unsigned, bit1 selects divide
    assign start = accept & (func[5:2] == 4'b0110);

    assign mf_sel  = md_op & ((func == F_MFHI) | (func == F_MFLO));
    assign mf_data = (func == F_MFLO) ? lo_r : hi_r;

    mdu_iter #(
        .WIDTH(WIDTH)
    ) u_iter (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .sgn    (~func[0]),
        .is_div (func[1]),
        .a      (op_a),
        .b      (op_b),
        .busy   (busy),
        .done   (done),
        .hi     (res_hi),
        .lo     (res_lo)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            hi_r <= '0;
            lo_r <= '0;
        end else if (done) begin
            hi_r <= res_hi;
            lo_r <= res_lo;
        end else if (accept) begin
            if (func == F_MTHI) hi_r <= op_a;
            if (func == F_MTLO) lo_r <= op_a;
        end
    end

endmodule

// File: tb/tb_alu_control_mdu.sv
// Directed bench for alu_control_mdu: decode table plus MDU sequences.
// Expected values are hand-computed constants.
module tb_alu_control_mdu;

    import alu_ctrl_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic [1:0]   alu_op;
    logic [5:0]   func;
    logic         valid;
    logic [W-1:0] op_a, op_b;
    logic [3:0]   alu_ctrl;
    logic         illegal, stall, busy, mf_sel;
    logic [W-1:0] mf_data;

    int n_cmp = 0;
    int n_bad = 0;

    alu_control_mdu #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .alu_op   (alu_op),
        .func     (func),
        .valid    (valid),
        .op_a     (op_a),
        .op_b     (op_b),
        .alu_ctrl (alu_ctrl),
        .illegal  (illegal),
        .stall    (stall),
        .busy     (busy),
        .mf_data  (mf_data),
        .mf_sel   (mf_sel)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic [1:0] op;
        logic [5:0] fn;
        logic [3:0] ctrl;
        logic       ill;
    } dec_t;

    dec_t tbl[21];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic issue(input logic [5:0] fn, input logic [W-1:0] a,
                         input logic [W-1:0] b);
        @(posedge clk); #1;
        alu_op = 2'b10; func = fn; op_a = a; op_b = b; valid = 1'b1;
        @(posedge clk); #1;
        valid = 1'b0;
        op_a = ~a;
        op_b = ~b;
    endtask

    task automatic wait_idle(output int cyc);
        cyc = 0;
        while (busy && cyc < 200) begin
            cyc++;
            @(posedge clk); #1;
        end
    endtask

    task automatic read_hilo(output logic [W-1:0] hi, output logic [W-1:0] lo);
        alu_op = 2'b10; valid = 1'b1;
        func = F_MFHI; #1; hi = mf_data;
        func = F_MFLO; #1; lo = mf_data;
        valid = 1'b0; #1;
    endtask

    task automatic run_op(input string nm, input logic [5:0] fn,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] eh, input logic [W-1:0] el);
        int c;
        logic [W-1:0] h, l;
        issue(fn, a, b);
        wait_idle(c);
        chk({nm, "_lat"}, 64'(c), 64'd33);
        read_hilo(h, l);
        chk({nm, "_hi"}, 64'(h), 64'(eh));
        chk({nm, "_lo"}, 64'(l), 64'(el));
    endtask

    initial begin
        int c;
        logic [W-1:0] h, l;

        rst = 1'b1; valid = 1'b0; alu_op = 2'b00; func = 6'd0;
        op_a = '0; op_b = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        chk("rst_busy", 64'(busy), 64'd0);
        read_hilo(h, l);
        chk("rst_hi", 64'(h), 64'd0);
        chk("rst_lo", 64'(l), 64'd0);

        tbl[0]  = '{2'b00, 6'b111111, 4'b0010, 1'b0};
        tbl[1]  = '{2'b01, 6'b100000, 4'b0110, 1'b0};
        tbl[2]  = '{2'b11, 6'b011000, 4'b0001, 1'b0};
        tbl[3]  = '{2'b10, 6'b100000, 4'b0010, 1'b0};
        tbl[4]  = '{2'b10, 6'b100010, 4'b0110, 1'b0};
        tbl[5]  = '{2'b10, 6'b100100, 4'b0000, 1'b0};
        tbl[6]  = '{2'b10, 6'b100101, 4'b0001, 1'b0};
        tbl[7]  = '{2'b10, 6'b101010, 4'b0111, 1'b0};
        tbl[8]  = '{2'b10, 6'b000000, 4'b1110, 1'b0};
        tbl[9]  = '{2'b10, 6'b000010, 4'b1101, 1'b0};
        tbl[10] = '{2'b10, 6'b100111, 4'b1100, 1'b0};
        tbl[11] = '{2'b10, 6'b011000, 4'b1111, 1'b0};
        tbl[12] = '{2'b10, 6'b011001, 4'b1111, 1'b0};
        tbl[13] = '{2'b10, 6'b011010, 4'b1111, 1'b0};
        tbl[14] = '{2'b10, 6'b011011, 4'b1111, 1'b0};
        tbl[15] = '{2'b10, 6'b010000, 4'b1111, 1'b0};
        tbl[16] = '{2'b10, 6'b010010, 4'b1111, 1'b0};
        tbl[17] = '{2'b10, 6'b010001, 4'b1111, 1'b0};
        tbl[18] = '{2'b10, 6'b010011, 4'b1111, 1'b0};
        tbl[19] = '{2'b10, 6'b111111, 4'b1111, 1'b1};
        tbl[20] = '{2'b10, 6'b000001, 4'b1111, 1'b1};

        valid = 1'b0;
        for (int i = 0; i < 21; i++) begin
            alu_op = tbl[i].op;
            func   = tbl[i].fn;
            #1;
            chk($sformatf("dec%0d_ctrl", i), 64'(alu_ctrl), 64'(tbl[i].ctrl));
            chk($sformatf("dec%0d_ill", i), 64'(illegal), 64'(tbl[i].ill));
        end

        run_op("mult",  F_MULT,  32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1);
        run_op("multu", F_MULTU, 32'hFFFFFFFD, 32'd5, 32'h00000004, 32'hFFFFFFF1);
        run_op("divu",  F_DIVU,  32'd100, 32'd7, 32'd2, 32'd14);
        run_op("div",   F_DIV,   32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op("div0",  F_DIV,   32'd5, 32'd0, 32'd5, 32'hFFFFFFFF);
        run_op("divn0", F_DIV,   32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 32'hFFFFFFFF);
        run_op("divmin", F_DIV,  32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000);

        // interlock: add never stalls, mflo waits for the result
        issue(F_MULT, 32'd7, 32'd6);
        alu_op = 2'b00; func = F_ADD; valid = 1'b1; #1;
        chk("add_nostall", 64'(stall), 64'd0);
        chk("add_ctrl", 64'(alu_ctrl), 64'(ALU_ADD));
        @(posedge clk); #1;
        alu_op = 2'b10; func = F_MFLO; valid = 1'b1; #1;
        chk("mflo_stall", 64'(stall), 64'd1);
        c = 0;
        while (stall && c < 200) begin
            c++;
            @(posedge clk); #1;
        end
        chk("mflo_stall_cyc", 64'(c), 64'd32);
        chk("mflo_data", 64'(mf_data), 64'd42);
        chk("mflo_sel", 64'(mf_sel), 64'd1);
        valid = 1'b0;

        // mthi in idle
        @(posedge clk); #1;
        alu_op = 2'b10; func = F_MTHI; op_a = 32'hA5A5A5A5; valid = 1'b1;
        @(posedge clk); #1;
        valid = 1'b0;
        read_hilo(h, l);
        chk("mthi_hi", 64'(h), 64'hA5A5A5A5);
        chk("mthi_lo", 64'(l), 64'd42);

        // mthi while busy: held off, then applied after the result
        issue(F_MULTU, 32'h00010000, 32'h00030000);
        alu_op = 2'b10; func = F_MTHI; op_a = 32'h12345678; valid = 1'b1; #1;
        chk("mthi_busy_stall", 64'(stall), 64'd1);
        c = 0;
        while (stall && c < 200) begin
            c++;
            @(posedge clk); #1;
        end
        chk("mthi_stall_cyc", 64'(c), 64'd33);
        @(posedge clk); #1;
        valid = 1'b0;
        read_hilo(h, l);
        chk("mthi_late_hi", 64'(h), 64'h12345678);
        chk("mthi_late_lo", 64'(l), 64'd0);

        // reset in RUN cycle 10 discards the operation
        issue(F_MULT, 32'd3, 32'd3);
        repeat (9) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_busy", 64'(busy), 64'd0);
        read_hilo(h, l);
        chk("midrst_hi", 64'(h), 64'd0);
        chk("midrst_lo", 64'(l), 64'd0);

        run_op("post_rst", F_MULT, 32'd2, 32'hFFFFFFFC, 32'hFFFFFFFF, 32'hFFFFFFF8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_control_mdu.md
Name: alu_control_mdu

Overview:
Next-generation ALU control for the MIPS core. It decodes alu_op/func to the 4-bit ALU control code and adds srl and nor. Illegal R-type functions resolve deterministically to a NOP code with a flag. It also owns an iterative multiply/divide unit with HI/LO registers and an issue interlock (stall) toward the PC/register-file stage. It sits between the main control unit and the ALU/writeback mux.

Parameters:
WIDTH, 32, operand/HI/LO width; legal values are 4..64.
CNT_W, $clog2(WIDTH+1), iteration counter width (localparam).

Ports:
clk  in  1  core clock
rst  in  1  synchronous active-high reset
alu_op  in  2  from main control: 00 add, 01 sub, 11 or, 10 R-type
func  in  6  instruction[5:0]
valid  in  1  instruction in decode is real (not a bubble)
op_a  in  WIDTH  rs value
op_b  in  WIDTH  rt value
alu_ctrl  out  4  ALU control code (combinational)
illegal  out  1  R-type func not recognised (combinational)
stall  out  1  hold PC/IF; current instruction is not accepted (combinational)
busy  out  1  mult/div in progress (registered)
mf_data  out  WIDTH  HI or LO for mfhi/mflo (combinational)
mf_sel  out  1  current instruction is mfhi/mflo; selects mf_data for writeback

Behaviour:
- Decode, purely combinational:
  - alu_op 00 -> 0010; 01 -> 0110; 11 -> 0001.
  - alu_op 10, ALU funcs: 100000 -> 0010; 100010 -> 0110; 100100 -> 0000; 100101 -> 0001; 101010 -> 0111; 000000 -> 1110 (sll); 000010 -> 1101 (srl); 100111 -> 1100 (nor).
  - alu_op 10, MDU funcs (alu_ctrl = 1111, illegal=0): 011000 mult, 011001 multu, 011010 div, 011011 divu, 010000 mfhi, 010010 mflo, 010001 mthi, 010011 mtlo.
  - Any other func: alu_ctrl=1111, illegal=1. No X outputs ever.
- md_op = valid & alu_op==10 & func is an MDU func.
- stall = busy & md_op. Non-MDU instructions never stall, including while busy.
- accept = md_op & ~stall.
- FSM IDLE / RUN / FIX:
  - IDLE, accept mult/div: latch |op_a| and |op_b| (abs only for signed ops), the sign bits and the op kind; cnt<=WIDTH; go RUN; busy<=1.
  - RUN: one radix-2 step per cycle. Multiply is shift-add producing a 2*WIDTH product. Divide is restoring division. cnt decrements each step; at cnt==1 the next state is FIX.
  - FIX: apply signs. Signed mult: negate the 2W product if sign_a^sign_b. Signed div: quotient negated if sign_a^sign_b; remainder takes sign_a. Write HI=product[2W-1:W] / remainder and LO=product[W-1:0] / quotient at the FIX edge. Next state IDLE, busy<=0.
  - Latency: accept at edge E. busy is high for cycles E+1..E+WIDTH+1 (WIDTH+1 cycles). HI/LO are valid from cycle E+WIDTH+2.
- Divide by zero: no exception. LO=all ones, HI=dividend (op_a as presented). Still takes the full latency.
- Signed MIN / -1: LO=MIN, HI=0 (falls out of the magnitude algorithm with width-truncated negation).
- mthi/mtlo accepted in IDLE: HI or LO <= op_a at that edge.
- mfhi/mflo: mf_data = HI or LO, mf_sel=1. If busy, the instruction stalls until busy falls, then reads the new value.
- Operands are sampled only at accept. op_a/op_b changing during RUN has no effect.
- Reset, including mid-operation: state IDLE, busy=0, cnt=0, HI=0, LO=0, all internal operand registers cleared. The in-flight operation is discarded.
- alu_ctrl, illegal and mf_sel do not depend on state. mf_data reflects HI/LO only.

Decomposition:
- Shared package alu_ctrl_pkg:
  - ALU code constants: ADD, SUB, AND, OR, SLT, SLL, SRL, NOR, NOP=1111.
  - Func constants, including MDU funcs.
  - ALU_OP enumeration.
  - FSM state typedef.
- One sub-module, mdu_iter: the RUN/FIX datapath with start, signed, is_div, a, b in and done, hi, lo out, parametrised on WIDTH.
- Decode, interlock and HI/LO writeback stay in the top.

Test Plan:
- Decode sweep: all alu_op values plus every listed func -> the codes above. func 111111 with alu_op 10 -> alu_ctrl=1111, illegal=1. alu_op 00 with any func -> 0010, illegal=0.
- mult op_a=FFFFFFFD (-3), op_b=5 -> busy for exactly 33 cycles; then HI=FFFFFFFF, LO=FFFFFFF1. multu of the same operands -> HI=00000004, LO=FFFFFFF1.
- divu 100/7 -> LO=14, HI=2. div -7/2 -> LO=FFFFFFFD, HI=FFFFFFFF. div 5/0 -> LO=FFFFFFFF, HI=5.
- Interlock: issue mult, then an add next cycle -> no stall. mflo two cycles later -> stall high until busy falls, then mf_data=new LO, mf_sel=1.
- mthi 0xA5A5A5A5 in IDLE, then mfhi -> mf_data=A5A5A5A5. mthi issued while busy -> stalled, no HI write until accepted.
- rst asserted at RUN cycle 10 -> next cycle busy=0, HI=LO=0. Subsequent mult completes correctly with full latency.
